// File: rtl/refill_line_buffer_pkg.sv
// Shared types and helpers for the multi-beat refill line buffer.
package refill_line_buffer_pkg;

    typedef enum logic [1:0] {
        FREE  = 2'b00,
        FILL  = 2'b01,
        VALID = 2'b10
    } rfbuf_state_e;

    // Number of beats that make up one cache line.
    function automatic int nbeat(input int line_w, input int beat_w);
        return line_w / beat_w;
    endfunction

    // Beat counter width; a single-beat line still keeps a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/refill_line_buffer_entry.sv
// One refill buffer entry: FREE/FILL/VALID state, id, beat counter and line data.
module refill_line_entry
    import refill_line_buffer_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int SET_W  = 6,
    parameter int WAY_W  = 2,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat_we,
    input  logic              beat_alloc,
    input  logic              beat_last,
    input  logic [BEAT_W-1:0] beat_data,
    input  logic [SET_W-1:0]  beat_set,
    input  logic [WAY_W-1:0]  beat_way,
    input  logic              deq,
    output logic [1:0]        state_o,
    output logic [SET_W-1:0]  set_o,
    output logic [WAY_W-1:0]  way_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic [LINE_W-1:0] line_o
);

    localparam int NBEAT = nbeat(LINE_W, BEAT_W);

    rfbuf_state_e      state_q, state_d;
    logic [SET_W-1:0]  set_q, set_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [CNT_W-1:0]  cnt_eff;
    logic              slot_final;
    int                slot_lo;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: allocate on first beat, close on last beat, free on dequeue
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FREE:    if (beat_alloc) state_d = beat_last ? VALID : FILL;
            FILL:    if (beat_we && beat_last) state_d = VALID;
            VALID:   if (deq) state_d = FREE;
            default: state_d = FREE;
        endcase
    end

    // Beat write: an allocating beat restarts the line at slot 0; the counter saturates at the final slot
    always_comb begin
        cnt_eff    = beat_alloc ? '0 : cnt_q;
        slot_final = (cnt_eff == CNT_W'(NBEAT - 1));
        slot_lo    = int'(cnt_eff) * BEAT_W;
        set_d      = set_q;
        way_d      = way_q;
        cnt_d      = cnt_q;
        line_d     = line_q;
        if (beat_alloc) begin
            set_d  = beat_set;
            way_d  = beat_way;
            line_d = '0;
        end
        if (beat_we) begin
            line_d[slot_lo +: BEAT_W] = beat_data;
            cnt_d = slot_final ? cnt_eff : cnt_eff + CNT_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_q  <= '0;
            way_q  <= '0;
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            set_q  <= set_d;
            way_q  <= way_d;
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

    assign state_o = state_q;
    assign set_o   = set_q;
    assign way_o   = way_q;
    assign cnt_o   = cnt_q;
    assign line_o  = line_q;

endmodule

// File: rtl/refill_line_buffer.sv
// Multi-beat refill line buffer: routes memory-controller beats into entries,
// reports VALID/FILL hits to the LSQ and hands completed lines to rc.
module refill_line_buffer
    import refill_line_buffer_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int DEPTH  = 4,
    parameter int SET_W  = 6,
    parameter int WAY_W  = 2,
    localparam int ID_W  = SET_W + WAY_W,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memctl_refill_valid,
    output logic              memctl_refill_ready,
    input  logic [ID_W-1:0]   memctl_refill_id,
    input  logic              memctl_refill_last,
    input  logic [BEAT_W-1:0] memctl_refill_data,
    input  logic              lsq_deq_confirm,
    input  logic [SET_W-1:0]  lsq_deq_set,
    input  logic [WAY_W-1:0]  lsq_deq_way,
    output logic              d_rc_hit_refill_buf,
    output logic              d_rc_hit_pending,
    input  logic              d_rc_ready,
    output logic [LINE_W-1:0] d_rc_refill_data,
    output logic [OCC_W-1:0]  occupancy,
    output logic              beat_err
);

    localparam int NBEAT = nbeat(LINE_W, BEAT_W);
    localparam int CNT_W = cnt_width(NBEAT);

    logic [DEPTH-1:0][1:0]        st_vec;
    logic [DEPTH-1:0][SET_W-1:0]  set_vec;
    logic [DEPTH-1:0][WAY_W-1:0]  way_vec;
    logic [DEPTH-1:0][CNT_W-1:0]  cnt_vec;
    logic [DEPTH-1:0][LINE_W-1:0] line_vec;

    logic [SET_W-1:0] beat_set;
    logic [WAY_W-1:0] beat_way;
    logic [DEPTH-1:0] fill_match, free_vec, hit_vec, pend_vec;
    logic [DEPTH-1:0] fill_oh, alloc_oh, hit_oh;
    logic [DEPTH-1:0] we_vec, alloc_vec, deq_vec;
    logic             fill_hit, accept, alloc_any, free_any, err_now;
    logic [CNT_W-1:0] cnt_sel;
    logic [OCC_W-1:0] occupancy_q, occupancy_d;
    logic             beat_err_q;

    assign beat_set = memctl_refill_id[SET_W-1:0];
    assign beat_way = memctl_refill_id[ID_W-1:SET_W];

    // Per-entry id match against the incoming beat and the LSQ lookup
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            fill_match[i] = (st_vec[i] == FILL) && (set_vec[i] == beat_set) && (way_vec[i] == beat_way);
            free_vec[i]   = (st_vec[i] == FREE);
            hit_vec[i]    = lsq_deq_confirm && (st_vec[i] == VALID) &&
                            (set_vec[i] == lsq_deq_set) && (way_vec[i] == lsq_deq_way);
            pend_vec[i]   = lsq_deq_confirm && (st_vec[i] == FILL) &&
                            (set_vec[i] == lsq_deq_set) && (way_vec[i] == lsq_deq_way);
        end
    end

    // Lowest-index priority selects and beat routing; a FILL id match beats allocation
    always_comb begin
        fill_oh   = fill_match & (~fill_match + DEPTH'(1));
        alloc_oh  = free_vec & (~free_vec + DEPTH'(1));
        hit_oh    = hit_vec & (~hit_vec + DEPTH'(1));
        fill_hit  = |fill_match;
        memctl_refill_ready = fill_hit | (|free_vec);
        accept    = memctl_refill_valid & memctl_refill_ready;
        alloc_any = accept & ~fill_hit;
        we_vec    = accept ? (fill_hit ? fill_oh : alloc_oh) : '0;
        alloc_vec = alloc_any ? alloc_oh : '0;
        d_rc_hit_refill_buf = |hit_vec;
        d_rc_hit_pending    = |pend_vec;
        free_any  = d_rc_hit_refill_buf & d_rc_ready;
        deq_vec   = free_any ? hit_oh : '0;
    end

    // Counter of the routed entry (0 when allocating) and rc data mux
    always_comb begin
        cnt_sel          = '0;
        d_rc_refill_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fill_oh[i]) cnt_sel = cnt_sel | cnt_vec[i];
            if (hit_oh[i]) d_rc_refill_data = d_rc_refill_data | line_vec[i];
        end
        err_now = accept & (memctl_refill_last ? (cnt_sel != CNT_W'(NBEAT - 1))
                                               : (cnt_sel == CNT_W'(NBEAT - 1)));
        occupancy_d = occupancy_q + OCC_W'(alloc_any) - OCC_W'(free_any);
    end

    // Occupancy counter and registered error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy_q <= '0;
            beat_err_q  <= 1'b0;
        end else begin
            occupancy_q <= occupancy_d;
            beat_err_q  <= err_now;
        end
    end

    assign occupancy = occupancy_q;
    assign beat_err  = beat_err_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        refill_line_entry #(
            .LINE_W (LINE_W),
            .BEAT_W (BEAT_W),
            .SET_W  (SET_W),
            .WAY_W  (WAY_W),
            .CNT_W  (CNT_W)
        ) u_entry (
            .clk        (clk),
            .rst        (rst),
            .beat_we    (we_vec[g]),
            .beat_alloc (alloc_vec[g]),
            .beat_last  (memctl_refill_last),
            .beat_data  (memctl_refill_data),
            .beat_set   (beat_set),
            .beat_way   (beat_way),
            .deq        (deq_vec[g]),
            .state_o    (st_vec[g]),
            .set_o      (set_vec[g]),
            .way_o      (way_vec[g]),
            .cnt_o      (cnt_vec[g]),
            .line_o     (line_vec[g])
        );
    end

endmodule

// File: tb/tb_refill_line_buffer.sv
// Directed bench for refill_line_buffer with default parameters.
module tb_refill_line_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         memctl_refill_valid;
    logic         memctl_refill_ready;
    logic [7:0]   memctl_refill_id;
    logic         memctl_refill_last;
    logic [63:0]  memctl_refill_data;
    logic         lsq_deq_confirm;
    logic [5:0]   lsq_deq_set;
    logic [1:0]   lsq_deq_way;
    logic         d_rc_hit_refill_buf;
    logic         d_rc_hit_pending;
    logic         d_rc_ready;
    logic [255:0] d_rc_refill_data;
    logic [2:0]   occupancy;
    logic         beat_err;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] S_FREE  = 2'b00;
    localparam logic [1:0] S_FILL  = 2'b01;
    localparam logic [1:0] S_VALID = 2'b10;

    refill_line_buffer dut (
        .clk                 (clk),
        .rst                 (rst),
        .memctl_refill_valid (memctl_refill_valid),
        .memctl_refill_ready (memctl_refill_ready),
        .memctl_refill_id    (memctl_refill_id),
        .memctl_refill_last  (memctl_refill_last),
        .memctl_refill_data  (memctl_refill_data),
        .lsq_deq_confirm     (lsq_deq_confirm),
        .lsq_deq_set         (lsq_deq_set),
        .lsq_deq_way         (lsq_deq_way),
        .d_rc_hit_refill_buf (d_rc_hit_refill_buf),
        .d_rc_hit_pending    (d_rc_hit_pending),
        .d_rc_ready          (d_rc_ready),
        .d_rc_refill_data    (d_rc_refill_data),
        .occupancy           (occupancy),
        .beat_err            (beat_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mkline(input logic [63:0] s0, input logic [63:0] s1,
                                            input logic [63:0] s2, input logic [63:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [7:0] id, input logic last, input logic [63:0] d);
        memctl_refill_valid = 1'b1;
        memctl_refill_id    = id;
        memctl_refill_last  = last;
        memctl_refill_data  = d;
    endtask

    task automatic idle_beat();
        memctl_refill_valid = 1'b0;
        memctl_refill_last  = 1'b0;
    endtask

    task automatic lookup(input logic [5:0] s, input logic [1:0] w, input logic rdy);
        lsq_deq_confirm = 1'b1;
        lsq_deq_set     = s;
        lsq_deq_way     = w;
        d_rc_ready      = rdy;
    endtask

    task automatic lookup_off();
        lsq_deq_confirm = 1'b0;
        d_rc_ready      = 1'b0;
    endtask

    task automatic send_line(input logic [7:0] id, input logic [63:0] base);
        for (int k = 0; k < 4; k++) begin
            drive_beat(id, (k == 3), base + 64'(k));
            cyc();
        end
        idle_beat();
    endtask

    task automatic deq_line(input string tag, input logic [5:0] s, input logic [1:0] w,
                            input logic [255:0] exp_line);
        lookup(s, w, 1'b0);
        #1;
        chk({tag, "_hit"}, d_rc_hit_refill_buf, 1'b1);
        chk({tag, "_data"}, d_rc_refill_data, exp_line);
        d_rc_ready = 1'b1;
        cyc();
        lookup_off();
    endtask

    initial begin
        rst = 1'b1;
        memctl_refill_valid = 1'b0;
        memctl_refill_id    = '0;
        memctl_refill_last  = 1'b0;
        memctl_refill_data  = '0;
        lsq_deq_confirm     = 1'b0;
        lsq_deq_set         = '0;
        lsq_deq_way         = '0;
        d_rc_ready          = 1'b0;

        // reset values
        #3;
        chk("rst_ready", memctl_refill_ready, 1'b1);
        chk("rst_hit", d_rc_hit_refill_buf, 1'b0);
        chk("rst_pend", d_rc_hit_pending, 1'b0);
        chk("rst_data", d_rc_refill_data, '0);
        chk("rst_occ", occupancy, 3'd0);
        chk("rst_err", beat_err, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;

        // A: four beats of id {1,5}, pending during the fill, hit after last
        lookup(6'd5, 2'd1, 1'b0);
        drive_beat(8'h45, 1'b0, 64'hA0);
        #1;
        chk("A_pend_b0", d_rc_hit_pending, 1'b0);
        chk("A_ready_b0", memctl_refill_ready, 1'b1);
        cyc();
        drive_beat(8'h45, 1'b0, 64'hA1);
        #1;
        chk("A_pend_b1", d_rc_hit_pending, 1'b1);
        chk("A_hit_b1", d_rc_hit_refill_buf, 1'b0);
        chk("A_occ_b1", occupancy, 3'd1);
        cyc();
        drive_beat(8'h45, 1'b0, 64'hA2);
        cyc();
        drive_beat(8'h45, 1'b1, 64'hA3);
        #1;
        chk("A_pend_last", d_rc_hit_pending, 1'b1);
        chk("A_hit_last", d_rc_hit_refill_buf, 1'b0);
        cyc();
        idle_beat();
        #1;
        chk("A_hit", d_rc_hit_refill_buf, 1'b1);
        chk("A_pend_done", d_rc_hit_pending, 1'b0);
        chk("A_data", d_rc_refill_data, mkline(64'hA0, 64'hA1, 64'hA2, 64'hA3));
        chk("A_occ_before", occupancy, 3'd1);
        chk("A_err", beat_err, 1'b0);
        d_rc_ready = 1'b1;
        cyc();
        lookup_off();
        #1;
        chk("A_occ_after", occupancy, 3'd0);

        // B: interleaved X={0,3} and Y={2,10}
        for (int k = 0; k < 4; k++) begin
            drive_beat(8'h03, (k == 3), 64'h10 + 64'(k));
            cyc();
            drive_beat(8'h8A, (k == 3), 64'h20 + 64'(k));
            cyc();
        end
        idle_beat();
        #1;
        chk("B_occ2", occupancy, 3'd2);
        chk("B_st0", dut.st_vec[0], S_VALID);
        chk("B_st1", dut.st_vec[1], S_VALID);
        deq_line("B_Y", 6'd10, 2'd2, mkline(64'h20, 64'h21, 64'h22, 64'h23));
        #1;
        chk("B_occ1", occupancy, 3'd1);
        chk("B_st1_free", dut.st_vec[1], S_FREE);
        deq_line("B_X", 6'd3, 2'd0, mkline(64'h10, 64'h11, 64'h12, 64'h13));
        #1;
        chk("B_occ0", occupancy, 3'd0);

        // C: full buffer, free entry 2, new id takes entry 2
        send_line(8'h01, 64'h100);
        send_line(8'h02, 64'h200);
        send_line(8'h03, 64'h300);
        send_line(8'h04, 64'h400);
        #1;
        chk("C_occ4", occupancy, 3'd4);
        drive_beat(8'h3F, 1'b0, 64'h500);
        #1;
        chk("C_full_ready", memctl_refill_ready, 1'b0);
        lookup(6'd3, 2'd0, 1'b1);
        #1;
        chk("C_ready_deq_cycle", memctl_refill_ready, 1'b0);
        chk("C_hit2", d_rc_hit_refill_buf, 1'b1);
        chk("C_data2", d_rc_refill_data, mkline(64'h300, 64'h301, 64'h302, 64'h303));
        cyc();
        lookup_off();
        #1;
        chk("C_ready_after", memctl_refill_ready, 1'b1);
        chk("C_st2_free", dut.st_vec[2], S_FREE);
        chk("C_occ3", occupancy, 3'd3);
        cyc();
        #1;
        chk("C_st2_fill", dut.st_vec[2], S_FILL);
        chk("C_occ4b", occupancy, 3'd4);
        drive_beat(8'h3F, 1'b0, 64'h501);
        #1;
        chk("C_ready_fillmatch", memctl_refill_ready, 1'b1);
        cyc();
        drive_beat(8'h3F, 1'b0, 64'h502);
        cyc();
        drive_beat(8'h3F, 1'b1, 64'h503);
        cyc();
        idle_beat();
        deq_line("C_e0", 6'd1, 2'd0, mkline(64'h100, 64'h101, 64'h102, 64'h103));
        deq_line("C_e1", 6'd2, 2'd0, mkline(64'h200, 64'h201, 64'h202, 64'h203));
        deq_line("C_e3", 6'd4, 2'd0, mkline(64'h400, 64'h401, 64'h402, 64'h403));
        deq_line("C_e2", 6'd63, 2'd0, mkline(64'h500, 64'h501, 64'h502, 64'h503));
        #1;
        chk("C_occ0", occupancy, 3'd0);

        // D1: last on the 2nd beat
        drive_beat(8'h07, 1'b0, 64'hB0);
        cyc();
        drive_beat(8'h07, 1'b1, 64'hB1);
        #1;
        chk("D_err_pre", beat_err, 1'b0);
        cyc();
        idle_beat();
        lookup(6'd7, 2'd0, 1'b0);
        #1;
        chk("D_err_pulse", beat_err, 1'b1);
        chk("D_occ1", occupancy, 3'd1);
        chk("D_hit", d_rc_hit_refill_buf, 1'b1);
        cyc();
        #1;
        chk("D_err_clear", beat_err, 1'b0);
        d_rc_ready = 1'b1;
        cyc();
        lookup_off();
        #1;
        chk("D_occ0", occupancy, 3'd0);

        // D2: no last on the final slot, then last on an extra beat
        for (int k = 0; k < 4; k++) begin
            drive_beat(8'h08, 1'b0, 64'hC0 + 64'(k));
            cyc();
        end
        drive_beat(8'h08, 1'b1, 64'hC4);
        #1;
        chk("D2_err_pulse", beat_err, 1'b1);
        chk("D2_st0_fill", dut.st_vec[0], S_FILL);
        cyc();
        idle_beat();
        #1;
        chk("D2_err_clear", beat_err, 1'b0);
        deq_line("D2", 6'd8, 2'd0, mkline(64'hC0, 64'hC1, 64'hC2, 64'hC4));

        // E: reset while two lines are mid-fill
        drive_beat(8'h45, 1'b0, 64'hD0);
        cyc();
        drive_beat(8'h45, 1'b0, 64'hD1);
        cyc();
        drive_beat(8'h46, 1'b0, 64'hE0);
        cyc();
        idle_beat();
        lookup(6'd5, 2'd1, 1'b0);
        #1;
        chk("E_pend_pre", d_rc_hit_pending, 1'b1);
        chk("E_occ_pre", occupancy, 3'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("E_occ_rst", occupancy, 3'd0);
        chk("E_pend_rst", d_rc_hit_pending, 1'b0);
        chk("E_hit_rst", d_rc_hit_refill_buf, 1'b0);
        chk("E_ready_rst", memctl_refill_ready, 1'b1);
        chk("E_data_rst", d_rc_refill_data, '0);
        chk("E_err_rst", beat_err, 1'b0);
        cyc();
        rst = 1'b0;
        drive_beat(8'h45, 1'b0, 64'hF0);
        cyc();
        #1;
        chk("E_st0_fill", dut.st_vec[0], S_FILL);
        chk("E_occ1", occupancy, 3'd1);
        drive_beat(8'h45, 1'b0, 64'hF1);
        cyc();
        drive_beat(8'h45, 1'b0, 64'hF2);
        cyc();
        drive_beat(8'h45, 1'b1, 64'hF3);
        cyc();
        idle_beat();
        deq_line("E", 6'd5, 2'd1, mkline(64'hF0, 64'hF1, 64'hF2, 64'hF3));

        // F: dequeue entry 0 and allocate a new id in the same cycle
        send_line(8'h11, 64'h600);
        send_line(8'h12, 64'h700);
        send_line(8'h13, 64'h800);
        #1;
        chk("F_occ3_pre", occupancy, 3'd3);
        lookup(6'd17, 2'd0, 1'b1);
        drive_beat(8'h14, 1'b0, 64'h900);
        #1;
        chk("F_ready", memctl_refill_ready, 1'b1);
        chk("F_hit", d_rc_hit_refill_buf, 1'b1);
        cyc();
        lookup_off();
        idle_beat();
        #1;
        chk("F_occ3_post", occupancy, 3'd3);
        chk("F_st3_fill", dut.st_vec[3], S_FILL);
        chk("F_st0_free", dut.st_vec[0], S_FREE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/refill_line_buffer.md
# refill_line_buffer

Parametrised successor to the single-beat refill buffer. It collects multi-beat cache-line refills from the memory controller and supports interleaved refill IDs. Each entry is tracked as FREE/FILL/VALID, and a completed line is handed to the downstream read channel (rc) once the LSQ confirms a dequeue for its set/way. The block sits in the ISU between the memory controller and the rc data path, and it also reports in-flight (partially filled) hits so the LSQ can stall rather than miss.

## Interface
- LINE_W, 256: cache line width in bits.
- BEAT_W, 64: refill beat width in bits. Must divide LINE_W. NBEAT = LINE_W/BEAT_W, which is ≥1.
- DEPTH, 4: number of entries, ≥2.
- SET_W, 6: set index width.
- WAY_W, 2: way index width. Refill id = {way, set}, with ID_W = SET_W+WAY_W.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- memctl_refill_valid  in  1  beat valid.
- memctl_refill_ready  out  1  beat accepted when valid&ready.
- memctl_refill_id  in  ID_W  line id as {way, set}.
- memctl_refill_last  in  1  final beat of this id.
- memctl_refill_data  in  BEAT_W  beat payload. Beats of one id arrive in ascending order.
- lsq_deq_confirm  in  1  LSQ lookup/dequeue request.
- lsq_deq_set  in  SET_W  lookup set.
- lsq_deq_way  in  WAY_W  lookup way.
- d_rc_hit_refill_buf  out  1  a VALID entry matches the lookup.
- d_rc_hit_pending  out  1  a FILL entry matches the lookup (LSQ must retry).
- d_rc_ready  in  1  rc accepts the line.
- d_rc_refill_data  out  LINE_W  data of the selected entry.
- occupancy  out  $clog2(DEPTH+1)  number of non-FREE entries.
- beat_err  out  1  one-cycle pulse on a beat-count protocol error.

## Operation
- Per-entry state:
  - FREE→FILL on the first accepted beat of an id.
  - FILL→VALID on an accepted beat with last=1.
  - VALID→FREE on a dequeue handshake.
- Per-entry registers: set, way, beat counter ($clog2(NBEAT) bits, minimum 1), and the data line.
- Beat routing:
  - If an entry in FILL holds the same id, the beat goes to that entry.
  - Otherwise the beat allocates the lowest-index FREE entry.
- memctl_refill_ready = (FILL match exists) | (any FREE entry). It is combinational on the current id.
- Data placement: an accepted beat writes line bits [cnt*BEAT_W +: BEAT_W], then cnt increments. cnt resets to 0 on allocation; a beat that allocates writes slot 0 in the same cycle.
- beat_err pulses if any of the following occurs:
  - last=1 while cnt≠NBEAT-1;
  - last=0 while cnt=NBEAT-1.
  - On error the entry still closes to VALID when last=1. When last=0 at the final slot, cnt saturates and the entry stays FILL.
- Lookup:
  - hit_vec[i] = lsq_deq_confirm & state[i]==VALID & set/way match.
  - pend_vec[i] is the same match with state FILL.
  - The selected entry is the lowest-index hit.
  - d_rc_hit_refill_buf = |hit_vec; d_rc_hit_pending = |pend_vec.
- Dequeue handshake = d_rc_hit_refill_buf & d_rc_ready. The selected entry returns to FREE.
- d_rc_refill_data equals the selected entry's line. It is don't-care (driven 0) when there is no hit.
- NBEAT=1 degenerates to single-beat behaviour, and every beat must carry last=1.

## Timing
- Reset values:
  - all entries FREE, counters 0, data 0;
  - memctl_refill_ready=1; d_rc_hit_refill_buf=0; d_rc_hit_pending=0; d_rc_refill_data=0; occupancy=0; beat_err=0.
- A reset mid-fill discards all partial lines. Subsequent beats of the aborted id allocate a fresh entry.
- Beat→VALID latency: a last beat accepted in cycle t gives a VALID entry and a possible hit in cycle t+1. It cannot be hit in cycle t (pending=1 in t).
- Lookup and data outputs are combinational from registered state, with zero added latency.
- A freed entry is visible as FREE in cycle t+1 after the dequeue in t. It is not re-allocatable in the same cycle, because allocation uses the pre-edge state.
- A beat and a dequeue in the same cycle are independent. Occupancy updates by (+alloc −free) in the same edge, so the net change can be 0.
- Full condition: all entries non-FREE and no FILL id match → ready=0. Beats of ids already in FILL are still accepted when full.
- beat_err is registered and pulses in t+1 after the offending beat.

## Structure
- Add to the shared mpc_types package:
  - rfbuf_state_e, with FREE=2'b00, FILL=2'b01, VALID=2'b10;
  - an NBEAT helper function.
- Sub-module refill_line_entry: one instance per entry. It holds the state, set/way/cnt/data registers and beat write. It exposes state, set, and way.
- Top level holds the id match, allocation priority encode, hit select, occupancy counter, and error register.
- Use the existing priority_encoder and ns_gnrl_dfflr cells. Their reset is adapted to active-high rst.

## Test plan
- Defaults (LINE_W=256, BEAT_W=64): four beats of id {1,5} with data 0xA0..0xA3 and last on the 4th. LSQ lookup set=5/way=1 during beats → pending=1, hit=0. Same lookup in the cycle after the last beat → hit=1 and data = {A3,A2,A1,A0} in 64-bit slots. With d_rc_ready=1, occupancy goes 1→0.
- Interleaved ids X and Y with alternating beats → two entries (indices 0 and 1), each line assembled correctly. Dequeue Y first, then X.
- Fill all 4 entries to VALID → ready=0 for a new id. Dequeue entry 2 in cycle t → ready=1 in t+1, and the new id allocates entry 2.
- last=1 on the 2nd beat → beat_err pulse in the next cycle. The entry becomes VALID; occupancy stays correct.
- Assert rst while entries are mid-fill → all outputs return to reset values asynchronously. A subsequent beat 0 of the same id allocates entry 0.
- Simultaneous dequeue of entry 0 and new-id allocation while 3 entries are busy → allocation goes to entry 3; occupancy is unchanged (3→3).
